// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared types and default parameters for the CNN front end.
//                Holds the window controller state encoding and the default
//                pixel width and kernel size.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DEF_WORD_SIZE  = 8;
    localparam int DEF_KERNEL_DIM = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } win_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/window_controller_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : window_controller_raster_counter
//  Description : Raster-order column/row position counter. Advances one pixel
//                per adv_i, wraps the column at the end of each row and flags
//                the final pixel of the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_controller_raster_counter #(
    parameter int IMG_WIDTH  = 540,
    parameter int IMG_HEIGHT = 540
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic                          adv_i,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
    output logic                          last_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Next position: step the column, carry into the row at end of line.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule
`default_nettype wire

// File: rtl/window_controller.sv
`default_nettype none
// ============================================================================
//  Module      : window_controller
//  Description : Sequencer for the line-buffered sliding-window datapath.
//                Gates raster pixels into the datapath, tracks position and
//                presents each fully populated KERNEL_DIM x KERNEL_DIM window
//                exactly once under downstream backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_controller
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int KERNEL_DIM = DEF_KERNEL_DIM,
    parameter int IMG_WIDTH  = 540,
    parameter int IMG_HEIGHT = 540
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [WORD_SIZE-1:0]          in_pixel,
    output logic                          in_ready,
    output logic                          shift_en,
    output logic [WORD_SIZE-1:0]          win_pixel,
    output logic                          line_clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    // Offset from the newest pixel back to the window's top-left corner.
    localparam logic [CW-1:0] KOFF_C = CW'(KERNEL_DIM - 1);
    localparam logic [RW-1:0] KOFF_R = RW'(KERNEL_DIM - 1);

    win_ctrl_state_t state_q, state_d;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_px;
    logic          qualify;
    logic          consume;

    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic          frame_done_q, frame_done_d;

    window_controller_raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == CLEAR),
        .adv_i   (shift_en),
        .col_o   (col),
        .row_o   (row),
        .last_o  (last_px)
    );

    // The pixel being accepted completes a window once it sits at or beyond
    // the kernel extent in both directions.
    assign qualify   = (row >= KOFF_R) && (col >= KOFF_C);
    assign consume   = out_valid_q && out_ready;
    assign shift_en  = in_valid && in_ready;
    assign win_pixel = in_pixel;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame sequencing from start through final consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (shift_en && last_px) state_d = FLUSH;
            FLUSH:   if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs: input acceptance and line-buffer flush strobe.
    always_comb begin
        in_ready   = 1'b0;
        line_clear = 1'b0;
        case (state_q)
            CLEAR:   line_clear = 1'b1;
            RUN:     in_ready   = !out_valid_q || out_ready;
            default: ;
        endcase
    end

    // Window hand-off: a new qualifying pixel replaces the window being
    // consumed in the same cycle, otherwise the window holds until taken.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        frame_done_d = 1'b0;
        if (shift_en && qualify) begin
            out_valid_d = 1'b1;
            out_row_d   = row - KOFF_R;
            out_col_d   = col - KOFF_C;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if ((state_q == FLUSH) && consume) begin
            frame_done_d = 1'b1;
        end
    end

    // Registered window outputs and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_window_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_controller
//  Description : Scoreboard bench for window_controller on a 5x4 image with a
//                3x3 kernel. Stimulus queues the expected window coordinates,
//                an independent monitor pops them on each window handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_controller;

    localparam int WS = 8;
    localparam int KD = 3;
    localparam int IW = 5;
    localparam int IH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [WS-1:0] in_pixel = '0;
    logic          in_ready;
    logic          shift_en;
    logic [WS-1:0] win_pixel;
    logic          line_clear;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    out_row;
    logic [2:0]    out_col;
    logic          frame_done;

    int errors = 0;
    int checks = 0;
    int shift_cnt = 0;
    int done_cnt = 0;
    int frames_expected = 0;
    int stall_id = 0;
    int served_id = 0;
    int stall_cnt = 0;
    int frame_no = 0;
    int exp_q[$];

    // Hand-computed window order for a 5x4 image, 3x3 kernel: row*16+col.
    int exp_win[6] = '{0, 1, 2, 16, 17, 18};

    window_controller #(
        .WORD_SIZE  (WS),
        .KERNEL_DIM (KD),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .win_pixel  (win_pixel),
        .line_clear (line_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Downstream ready: holds off for three cycles of the first window of a
    // frame whenever a stall has been requested.
    always @(posedge clk) begin
        #1;
        if (stall_id != served_id && out_valid) begin
            stall_cnt++;
            if (stall_cnt >= 4) begin
                served_id = stall_id;
                stall_cnt = 0;
            end
        end
        out_ready = (stall_id == served_id);
    end

    // Monitor: scoreboard pops, stall hold checks, pulse counting.
    always @(negedge clk) begin
        if (!rst) begin
            if (shift_en) begin
                shift_cnt++;
                check("win_pixel", int'(win_pixel), int'(in_pixel));
            end
            if (frame_done) done_cnt++;
            if (stall_id != served_id && out_valid) begin
                check("stall_coord", int'(out_row) * 16 + int'(out_col), 0);
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_shift_en", int'(shift_en), 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL window_extra: got %0d expected none", int'(out_row) * 16 + int'(out_col));
                end else begin
                    check("window", int'(out_row) * 16 + int'(out_col), exp_q.pop_front());
                end
            end
        end
    end

    // Present pixels until n have been accepted; gap=1 gives 50% idle slots.
    task automatic feed(input int n, input bit gap);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 400) begin
            @(posedge clk); #1;
            in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel = WS'($urandom);
            @(negedge clk);
            if (shift_en) acc++;
            cyc++;
        end
        if (acc < n) check("feed_timeout", acc, n);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One frame; returns at the negedge of the frame_done cycle.
    task automatic run_frame(input bit skip_start, input bit stall, input bit gap, input bit mid_start);
        int base = shift_cnt;
        int cyc = 0;
        frame_no++;
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_win[i]);
        if (stall) stall_id = frame_no;
        if (!skip_start) begin
            @(posedge clk); #1;
            start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("line_clear_pulse", int'(line_clear), 1);
        check("clear_in_ready", int'(in_ready), 0);
        if (mid_start) begin
            feed(7, gap);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("run_start_ignored", int'(line_clear), 0);
            feed(13, gap);
        end else begin
            feed(20, gap);
        end
        while (!frame_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("frame_done_seen", int'(frame_done), 1);
        check("windows_left", exp_q.size(), 0);
        check("shift_count", shift_cnt - base, 20);
        frames_expected++;
    endtask

    initial begin
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_shift_en", int'(shift_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pos", int'(out_row) * 16 + int'(out_col), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_line_clear", int'(line_clear), 0);
        rst = 1'b0;

        // in_valid in IDLE is ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_shift_en", int'(shift_en), 0);
            check("idle_in_ready", int'(in_ready), 0);
            check("idle_line_clear", int'(line_clear), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Plain frame with a stray start mid-frame.
        run_frame(1'b0, 1'b0, 1'b0, 1'b1);
        // Back-to-back: start during the frame_done (first IDLE) cycle.
        start = 1'b1;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        // Downstream stall at the first window.
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);
        // Random input gaps.
        run_frame(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame after 12 accepted pixels.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(12, 1'b0);
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_shift_en", int'(shift_en), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_pos", int'(out_row) * 16 + int'(out_col), 0);
        check("mid_rst_frame_done", int'(frame_done), 0);
        check("mid_rst_line_clear", int'(line_clear), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("frame_done_pulses", done_cnt, frames_expected);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
